instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Prefetching instruction-fetch stage that sits directly upstream of the pipelined CPU's decode stage. It drives word addresses into the instruction memory, captures the returned words with their PCs in a small FIFO, and presents them to the CPU over a valid/ready handshake. A redirect input (taken branch, j, jal, jr) flushes all buffered and in-flight words and restarts fetch at the new PC.

## Interface
- DEPTH, 4: FIFO entries; a power of two, at least 2.
- ADDR_W, 16: PC / instruction-memory byte-address width.
- DATA_W, 32: instruction word width.

- clock  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  byte address of the request; bits [1:0] are always 0.
- imem_rdata  in  DATA_W  instruction word, valid exactly one cycle after the matching imem_req.
- instr  out  DATA_W  instruction at the FIFO head.
- instr_pc  out  ADDR_W  PC of instr.
- instr_valid  out  1  the FIFO head is valid.
- instr_ready  in  1  the CPU accepts the head this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] are ignored and forced to 0.

## Operation
- State:
  - fetch_pc
  - FIFO of {pc, word}, with rd_ptr, wr_ptr and count
  - inflight flag plus inflight_pc, for the request issued last cycle
- Issue rule:
  - imem_req = !redirect && (count + inflight) < DEPTH.
  - imem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W (0xFFFC -> 0x0000).
  - On issue: inflight <= 1 and inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- Capture: when inflight = 1 and no redirect this cycle, push {inflight_pc, imem_rdata} at wr_ptr.
- Pop: when instr_valid && instr_ready, rd_ptr advances.
- Outputs:
  - instr_valid = (count != 0).
  - instr and instr_pc are the head entry.
- Simultaneous push and pop: allowed, count is unchanged. Push into a full FIFO cannot happen, because the issue rule reserves space.
- Redirect (highest priority, overrides push, pop and issue in that cycle):
  - Pointers and count go to 0; inflight goes to 0, so the response arriving next cycle is dropped.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - imem_req = 0 in the redirect cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Instruction word 0x00000000 is queued like any other word; halting is the CPU's decision.
- Reset (asynchronous, any time, including mid-redirect or while a request is in flight):
  - fetch_pc = 0, count = 0, pointers = 0, inflight = 0.
  - imem_req = 0 while rst_n is low.
  - instr_valid = 0.
  - instr = 0 and instr_pc = 0; the storage array resets to 0.

## Timing
- Issue-to-visibility latency is 2 cycles: request in cycle N, data captured at the end of N+1, instr_valid high in cycle N+2.
- First fetch is in the first cycle after rst_n rises (address 0x0000); instr_valid rises 2 cycles later.
- Redirect at edge E:
  - no request in the cycle before E;
  - request for the new PC in the cycle after E;
  - first new instruction valid 3 cycles after the redirect cycle.
- Steady state with instr_ready held high: one instruction per cycle, with no bubbles, once the pipe is filled.
- No combinational path from instr_ready to imem_req. Space is computed from registered count and inflight only, so a pop frees the slot one cycle later.
- No combinational path from imem_rdata to any output.

## Structure
- Shared package `fetch_pkg` holds:
  - the DEPTH and ADDR_W defaults;
  - the fetch_entry_t struct {pc, word};
  - the PC_INC = 4 constant.
- The CPU's pc-width constant is shared with the package.
- One sub-module: `fetch_fifo`, a parameterised synchronous FIFO with push, pop, flush, full/empty and count, using the asynchronous active-low reset.
- Issue, inflight and redirect logic live in the top level.

## Test plan
- Reset release with instr_ready=1 and memory word = address:
  - imem_addr runs 0x0, 0x4, 0x8, … from cycle 1;
  - instr_valid rises in cycle 3 with instr_pc=0x0000, instr=0x00000000;
  - then one instruction per cycle.
- instr_ready=0 from reset:
  - exactly 4 requests are issued, then imem_req stays low;
  - count=4 and instr_valid holds.
  - Raising instr_ready for 1 cycle pops 0x0; exactly one new request (address 0x10) is issued the following cycle.
- Redirect to 0x0041 while the FIFO holds 3 entries and a request is in flight:
  - next-cycle imem_addr=0x0040;
  - instr_valid low until the 0x0040 word emerges;
  - no stale PC is ever presented.
- Redirect to 0xFFF8, then free-running fetch: imem_addr sequence is 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- Redirect in the same cycle as a pop and a capture:
  - the FIFO empties;
  - the captured word is dropped;
  - the popped entry is the last old output.
- rst_n asserted mid-stream between edges: imem_req, instr_valid, instr and instr_pc go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the queued-entry layout
// for the instruction-fetch stage.
package fetch_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // PC width shared with the CPU core.
  localparam int PC_W = ADDR_W_DEF;

  localparam int PC_INC = 4;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [DATA_W_DEF-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; flush beats
// push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = PC_W + DATA_W_DEF
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Entry storage; cleared on reset so the
  // head reads zero until something lands.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetching fetch stage: issues imem reads,
// buffers {pc, word}, hands them to decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = PC_W,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       used;
  logic              space;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [W-1:0]      head;

  // Slots already spoken for: buffered plus
  // the one response still on its way back.
  assign used  = {1'b0, count} + (CW+1)'(inflight);
  assign space = (used < (CW+1)'(DEPTH));

  assign imem_req  = rst_n && !redirect && space;
  assign imem_addr = fetch_pc;

  assign push = inflight && !redirect && !full;
  assign pop  = instr_valid && instr_ready
             && !redirect;

  assign instr_valid = !empty;
  assign instr_pc    = head[W-1:DATA_W];
  assign instr       = head[DATA_W-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({inflight_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Fetch PC and in-flight tracking; a
  // redirect kills the pending response.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~ADDR_W'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + ADDR_W'(PC_INC);
        inflight_pc <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue
// against a queue-based reference model.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  int total = 0;
  int bad   = 0;
  int nreq  = 0;

  logic [31:0]  salt = '0;
  fetch_entry_t q[$];
  logic [15:0]  mpc;
  logic         pend;
  logic [15:0]  pend_pc;
  logic         last_req;
  logic [15:0]  last_addr;

  always #5 clock = ~clock;

  instr_fetch_queue dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  function automatic logic [31:0] word_of(
    input logic [15:0] a);
    return {16'h0, a} ^ salt;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc      = '0;
    pend     = 1'b0;
    pend_pc  = '0;
    last_req = 1'b0;
    last_addr = '0;
  endtask

  // Entered at a falling edge; one cycle.
  task automatic step(input logic rdy,
                      input logic rd,
                      input logic [15:0] rpc);
    logic         ereq;
    fetch_entry_t e;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = last_req ? word_of(last_addr)
                           : $urandom;
    #1;
    ereq = !rd && (q.size() + int'(pend)) < 4;
    chk("req", imem_req, ereq);
    if (ereq) chk("addr", imem_addr, mpc);
    chk("valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("pc", instr_pc, q[0].pc);
      chk("instr", instr, q[0].word);
    end
    last_req  = imem_req;
    last_addr = imem_addr;
    if (imem_req) nreq++;
    if (rd) begin
      q.delete();
      pend = 1'b0;
      mpc  = rpc & 16'hFFFC;
    end else begin
      if (q.size() != 0 && rdy)
        void'(q.pop_front());
      if (pend) begin
        e.pc   = pend_pc;
        e.word = word_of(pend_pc);
        q.push_back(e);
      end
      pend = ereq;
      if (ereq) begin
        pend_pc = mpc;
        mpc     = mpc + 16'd4;
      end
    end
    @(negedge clock);
  endtask

  // Hold reset, check idle outputs, release
  // on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    redirect_pc = '0;
    imem_rdata = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    @(negedge clock);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    do_reset();

    // Free-running from reset, word = address.
    repeat (10) step(1'b1, 1'b0, '0);

    // Stall from reset: four requests only.
    do_reset();
    nreq = 0;
    repeat (8) step(1'b0, 1'b0, '0);
    chk("nreq_full", nreq, 4);
    chk("full_head", instr_pc, 16'h0000);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);

    // Redirect with 3 queued and one in flight.
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'h0041);
    repeat (8) step(1'b1, 1'b0, '0);

    // Address wrap at the top of memory.
    step(1'b1, 1'b1, 16'hFFF8);
    repeat (6) step(1'b1, 1'b0, '0);

    // Redirect with pop and capture together.
    salt = 32'hA5A5_0000;
    repeat (5) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 16'h0200);
    repeat (4) step(1'b1, 1'b0, '0);

    // Asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_valid", instr_valid, 0);
    chk("arst_instr", instr, 0);
    chk("arst_pc", instr_pc, 0);
    @(negedge clock);
    rst_n = 1'b1;
    model_reset();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) salt = $urandom;
      step(($urandom % 4) != 0,
           ($urandom % 12) == 0,
           16'($urandom));
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
